// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared types and constants for the RV32I fetch stage.
// XLEN, the canonical NOP, the fetch FSM encoding and a PC alignment helper.
package riscv_fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetchState_t;

    // Clear the byte-offset bits so the result is a legal word address.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pcIn);
        return pcIn & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// riscv_fetch_if: bundles the fetch stage's instruction-memory port and its
// decode/execute-facing signals. The master modport is the fetch stage.
//
// Handshakes:
//   imem address phase: a request is accepted in a cycle where o_imem_req and
//   i_imem_gnt are both high; o_imem_req/o_imem_addr are held stable until then.
//   imem data phase: i_imem_rvalid is a one-cycle pulse carrying i_imem_rdata,
//   at least one cycle after the accepting gnt; only one request is ever open.
//   decode: an instruction transfers in a cycle where o_validF is high and
//   i_stallF is low; while stalled the presented outputs do not change.
interface riscv_fetch_if;
    import riscv_fetch_pkg::*;

    logic            i_stallF;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;
    logic [XLEN-1:0] o_instrF;
    logic [XLEN-1:0] o_PCF;
    logic [XLEN-1:0] o_PCPLUS4F;
    logic            o_validF;

    modport master (
        input  i_stallF, i_redirect, i_redirect_pc,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_imem_req, o_imem_addr,
        output o_instrF, o_PCF, o_PCPLUS4F, o_validF
    );

    modport slave (
        output i_stallF, i_redirect, i_redirect_pc,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_imem_req, o_imem_addr,
        input  o_instrF, o_PCF, o_PCPLUS4F, o_validF
    );

endinterface

// File: rtl/riscv_pc.sv
// riscv_pc: program counter register. Redirect takes priority over the
// sequential increment; arithmetic wraps modulo 2^XLEN.
module riscv_pc
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            incEn,
    input  logic            redirEn,
    input  logic [XLEN-1:0] redirPc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4
);

    logic [XLEN-1:0] pcQ;

    // PC update: redirect target first, then +4 on a completed transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcQ <= RESET_PC;
        end else if (redirEn) begin
            pcQ <= redirPc;
        end else if (incEn) begin
            pcQ <= pcQ + XLEN'(4);
        end
    end

    assign pc      = pcQ;
    assign pcPlus4 = pcQ + XLEN'(4);

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: RV32I instruction-fetch stage. Owns the PC, issues one
// outstanding imem request at a time, holds the fetched word for decode and
// discards in-flight fetches on an execute redirect.
// Optional feature macro: RISCV_FETCH_MISALIGN_EN (misaligned-target detection,
// adds o_misalignF). Without it, redirect targets are forced word aligned.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    riscv_fetch_if.master bus,
    output fetchState_t   dbgState
`ifdef RISCV_FETCH_MISALIGN_EN
    ,
    output logic          o_misalignF
`endif
);

    fetchState_t     state;
    fetchState_t     nextState;
    logic            drop;
    logic            dropNext;
    logic            misalign;
    logic            misalignNext;
    logic [XLEN-1:0] instrHold;
    logic            captureRdata;
    logic            loadNop;
    logic            pcIncEn;
    logic            reqOut;
    logic            gntSeen;
    logic [XLEN-1:0] redirTarget;
    logic            redirMisaligned;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;

`ifdef RISCV_FETCH_MISALIGN_EN
    assign redirTarget     = bus.i_redirect_pc;
    assign redirMisaligned = (bus.i_redirect_pc[1:0] != 2'b00);
`else
    assign redirTarget     = alignPc(bus.i_redirect_pc);
    assign redirMisaligned = 1'b0;
`endif

    riscv_pc #(
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .incEn   (pcIncEn),
        .redirEn (bus.i_redirect),
        .redirPc (redirTarget),
        .pc      (pc),
        .pcPlus4 (pcPlus4)
    );

    // A request is withheld while a dropped response is still owed, so the
    // memory never sees two open transactions.
    assign reqOut  = (state == S_REQ) && !drop;
    assign gntSeen = reqOut && bus.i_imem_gnt;

    // FSM state, drop flag, misalign flag and instruction hold register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_IDLE;
            drop      <= 1'b0;
            misalign  <= 1'b0;
            instrHold <= NOP;
        end else begin
            state    <= nextState;
            drop     <= dropNext;
            misalign <= misalignNext;
            if (loadNop) begin
                instrHold <= NOP;
            end else if (captureRdata) begin
                instrHold <= bus.i_imem_rdata;
            end
        end
    end

    // Next-state logic; the redirect block at the end overrides normal flow.
    always_comb begin
        nextState    = state;
        dropNext     = drop;
        misalignNext = misalign;
        captureRdata = 1'b0;
        loadNop      = 1'b0;
        pcIncEn      = 1'b0;

        // Any response arriving outside S_WAIT belongs to an abandoned request.
        if (bus.i_imem_rvalid && (state != S_WAIT)) begin
            dropNext = 1'b0;
        end

        case (state)
            S_IDLE: nextState = S_REQ;
            S_REQ: begin
                if (gntSeen) begin
                    nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_imem_rvalid) begin
                    if (drop) begin
                        dropNext  = 1'b0;
                        nextState = S_REQ;
                    end else begin
                        captureRdata = 1'b1;
                        nextState    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A misaligned-target hold never advances the PC.
                if (!bus.i_stallF && !misalign) begin
                    pcIncEn   = 1'b1;
                    nextState = S_REQ;
                end
            end
            default: nextState = S_IDLE;
        endcase

        if (bus.i_redirect) begin
            pcIncEn      = 1'b0;
            captureRdata = 1'b0;
            misalignNext = 1'b0;
            case (state)
                S_IDLE: nextState = S_REQ;
                S_REQ: begin
                    if (gntSeen) begin
                        dropNext  = 1'b1;
                        nextState = S_WAIT;
                    end else begin
                        nextState = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.i_imem_rvalid) begin
                        dropNext  = 1'b0;
                        nextState = S_REQ;
                    end else begin
                        dropNext  = 1'b1;
                        nextState = S_WAIT;
                    end
                end
                S_HOLD:  nextState = S_REQ;
                default: nextState = S_REQ;
            endcase
            // Misaligned target: present a NOP marker instead of fetching.
            if (redirMisaligned) begin
                nextState    = S_HOLD;
                loadNop      = 1'b1;
                misalignNext = 1'b1;
            end
        end
    end

    assign bus.o_imem_req  = reqOut;
    assign bus.o_imem_addr = pc;
    assign bus.o_instrF    = instrHold;
    assign bus.o_PCF       = pc;
    assign bus.o_PCPLUS4F  = pcPlus4;
    assign bus.o_validF    = (state == S_HOLD);
    assign dbgState        = state;
`ifdef RISCV_FETCH_MISALIGN_EN
    assign o_misalignF     = misalign;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed bench for riscv_fetch with a cycle-stepped memory
// responder and an expected-instruction queue.
module tb_riscv_fetch;
    import riscv_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    fetchState_t dbgState;
`ifdef RISCV_FETCH_MISALIGN_EN
    logic        misalignF;
`endif

    riscv_fetch_if fif ();

    riscv_fetch #(
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .bus      (fif.master),
        .dbgState (dbgState)
`ifdef RISCV_FETCH_MISALIGN_EN
        ,
        .o_misalignF (misalignF)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          gntCyc[$];
    int          cyc = 0;
    int          lastRvCyc = 0;
    int          memLat = 1;
    int          cnt = 0;
    logic        gntEn = 1'b1;
    logic        stallRand = 1'b0;
    logic        stallF = 1'b0;
    logic        pending = 1'b0;
    logic        txStale = 1'b0;
    logic [31:0] txAddr = 32'h0;
    logic [31:0] expAddr = RESET_PC;
    logic        redirReq = 1'b0;
    logic [31:0] redirTgt = 32'h0;
    logic        expMis = 1'b0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h00A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: check visible outputs, drive memory/decode/execute inputs,
    // update expectations, advance to the next negedge.
    task automatic step();
        logic        doRedir;
        logic        rvNow;
        logic        gntNow;
        logic [31:0] rvAddr;
        logic [31:0] tgt;
        if (fif.o_validF === 1'b1) begin
            chk("req_in_hold", 32'(fif.o_imem_req), 32'd0);
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 32'(fif.o_validF), 32'd0);
            end else begin
                chk("pcF", fif.o_PCF, exp_q[0][63:32]);
                chk("pcPlus4F", fif.o_PCPLUS4F, exp_q[0][63:32] + 32'd4);
                chk("instrF", fif.o_instrF, exp_q[0][31:0]);
            end
        end
`ifdef RISCV_FETCH_MISALIGN_EN
        chk("misalignF", 32'(misalignF), 32'(expMis));
`endif
        if (stallRand) stallF = 1'($urandom_range(0, 1));
        doRedir  = redirReq;
        tgt      = redirTgt;
        redirReq = 1'b0;
        rvNow    = 1'b0;
        rvAddr   = txAddr;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                rvNow     = 1'b1;
                pending   = 1'b0;
                lastRvCyc = cyc;
                if (!txStale && !doRedir) exp_q.push_back({rvAddr, memWord(rvAddr)});
            end
        end
        gntNow = (fif.o_imem_req === 1'b1) && gntEn && !pending;
        if (gntNow) begin
            chk("req_addr", fif.o_imem_addr, expAddr);
            txAddr  = expAddr;
            txStale = 1'b0;
            pending = 1'b1;
            cnt     = memLat;
            gntCyc.push_back(cyc);
        end
        if (doRedir) begin
            if (pending) txStale = 1'b1;
            if (fif.o_validF === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
`ifdef RISCV_FETCH_MISALIGN_EN
            if (tgt[1:0] != 2'b00) begin
                exp_q.push_back({tgt, NOP});
                expMis = 1'b1;
            end else begin
                expMis  = 1'b0;
                expAddr = tgt;
            end
`else
            expAddr = {tgt[31:2], 2'b00};
`endif
        end else if (fif.o_validF === 1'b1 && !stallF && !expMis) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            expAddr = expAddr + 32'd4;
        end
        fif.i_imem_gnt    = gntNow;
        fif.i_imem_rvalid = rvNow;
        fif.i_imem_rdata  = rvNow ? memWord(rvAddr) : $urandom;
        fif.i_redirect    = doRedir;
        fif.i_redirect_pc = doRedir ? tgt : $urandom;
        fif.i_stallF      = stallF;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic runUntilValid(input int maxCycles);
        int n = 0;
        while (fif.o_validF !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        chk("valid_timeout", 32'(fif.o_validF), 32'd1);
    endtask

    task automatic runUntilReq(input int maxCycles);
        int n = 0;
        while (fif.o_imem_req !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        chk("req_timeout", 32'(fif.o_imem_req), 32'd1);
    endtask

    // Directed sequence, then a short randomized stretch, then the report.
    initial begin
        rstn              = 1'b0;
        fif.i_stallF      = 1'b0;
        fif.i_redirect    = 1'b0;
        fif.i_redirect_pc = 32'h0;
        fif.i_imem_gnt    = 1'b0;
        fif.i_imem_rvalid = 1'b0;
        fif.i_imem_rdata  = 32'h0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_req", 32'(fif.o_imem_req), 32'd0);
        chk("rst_addr", fif.o_imem_addr, RESET_PC);
        chk("rst_valid", 32'(fif.o_validF), 32'd0);
        chk("rst_instr", fif.o_instrF, 32'h0000_0013);
        chk("rst_pcF", fif.o_PCF, RESET_PC);
        chk("rst_pcPlus4F", fif.o_PCPLUS4F, RESET_PC + 32'd4);
        chk("rst_state", 32'(dbgState), 32'(S_IDLE));
`ifdef RISCV_FETCH_MISALIGN_EN
        chk("rst_misalign", 32'(misalignF), 32'd0);
`endif
        rstn = 1'b1;
        #1;
        chk("release_req_low", 32'(fif.o_imem_req), 32'd0);
        step();
        chk("first_req", 32'(fif.o_imem_req), 32'd1);

        // zero-wait fetch of 0x0, 0x4, then stall at 0x8
        memLat = 1;
        runUntilValid(20);
        step();
        runUntilValid(20);
        step();
        stallF = 1'b1;
        runUntilValid(20);
        chk("hold_pc8", fif.o_PCF, 32'h8);
        repeat (5) step();
        chk("stall_still_valid", 32'(fif.o_validF), 32'd1);
        chk("gnt_spacing_01", 32'(gntCyc[1] - gntCyc[0]), 32'd3);
        chk("gnt_spacing_12", 32'(gntCyc[2] - gntCyc[1]), 32'd3);
        stallF = 1'b0;
        memLat = 3;
        step();
        chk("req_after_stall", 32'(fif.o_imem_req), 32'd1);
        chk("addr_after_stall", fif.o_imem_addr, 32'hC);

        // redirect in S_WAIT with 3-cycle latency
        step();
        chk("wait_state", 32'(dbgState), 32'(S_WAIT));
        redirReq = 1'b1;
        redirTgt = 32'h100;
        step();
        runUntilReq(20);
        chk("redir_wait_latency", 32'(cyc - lastRvCyc), 32'd1);
        chk("redir_wait_addr", fif.o_imem_addr, 32'h100);
        runUntilValid(20);

        // redirect from S_HOLD, then redirect coinciding with gnt
        memLat   = 1;
        redirReq = 1'b1;
        redirTgt = 32'h20;
        step();
        chk("hold_redir_valid", 32'(fif.o_validF), 32'd0);
        chk("hold_redir_req", 32'(fif.o_imem_req), 32'd1);
        chk("hold_redir_addr", fif.o_imem_addr, 32'h20);
        redirReq = 1'b1;
        redirTgt = 32'h40;
        step();
        runUntilValid(20);
        chk("after_gnt_redir_pc", fif.o_PCF, 32'h40);
        step();

        // reset asserted in S_WAIT, stale rvalid after release
        memLat = 4;
        runUntilReq(20);
        step();
        chk("pre_reset_wait", 32'(dbgState), 32'(S_WAIT));
        rstn = 1'b0;
        #1;
        chk("async_reset_state", 32'(dbgState), 32'(S_IDLE));
        chk("async_reset_instr", fif.o_instrF, 32'h0000_0013);
        txStale = 1'b1;
        exp_q.delete();
        expAddr = RESET_PC;
        expMis  = 1'b0;
        step();
        step();
        gntEn = 1'b0;
        rstn  = 1'b1;
        step();
        step();
        chk("stale_ignored_state", 32'(dbgState), 32'(S_REQ));
        chk("stale_ignored_valid", 32'(fif.o_validF), 32'd0);
        gntEn  = 1'b1;
        memLat = 1;
        runUntilValid(20);
        chk("restart_pc", fif.o_PCF, RESET_PC);

        // PC wrap at the top of the address space
        redirReq = 1'b1;
        redirTgt = 32'hFFFF_FFFC;
        step();
        runUntilValid(20);
        chk("wrap_pcPlus4", fif.o_PCPLUS4F, 32'h0);
        step();
        runUntilValid(20);
        chk("wrap_next_pc", fif.o_PCF, 32'h0);

`ifdef RISCV_FETCH_MISALIGN_EN
        // misaligned target: NOP marker held until the next redirect
        redirReq = 1'b1;
        redirTgt = 32'h102;
        step();
        chk("mis_req", 32'(fif.o_imem_req), 32'd0);
        chk("mis_flag", 32'(misalignF), 32'd1);
        chk("mis_pcF", fif.o_PCF, 32'h102);
        chk("mis_instr", fif.o_instrF, 32'h0000_0013);
        repeat (3) step();
        chk("mis_pc_held", fif.o_PCF, 32'h102);
        redirReq = 1'b1;
        redirTgt = 32'h200;
        step();
        chk("mis_cleared", 32'(misalignF), 32'd0);
        runUntilValid(20);
        chk("mis_resume_pc", fif.o_PCF, 32'h200);
`else
        // low target bits are dropped on capture
        redirReq = 1'b1;
        redirTgt = 32'h1C3;
        step();
        chk("aligned_addr", fif.o_imem_addr, 32'h1C0);
        runUntilValid(20);
`endif

        // random memory latency and decode stalls
        stallRand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            memLat = $urandom_range(1, 3);
            step();
        end
        stallRand = 1'b0;
        stallF    = 1'b0;
        gntEn     = 1'b0;
        repeat (10) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
